// File: rtl/s0_rs_enc_lfsr4.sv
// ============================================================================
// Module   : s0_rs_enc_lfsr4
// Brief    : Systematic RS(K+4,K) encoder over GF(2^8), poly 0x11D, fcr=0.
//            Data symbols pass through one cycle late, followed by the four
//            parity symbols P3..P0 taken from a 4-stage LFSR.
//            g(x) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40
// Options  : RS_ENC_ERRINJ_EN - adds the err_inj port; it XOR-masks the
//            emitted data symbol only, so the LFSR still sees the clean data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef D
`define D
`endif

module s0_rs_enc_lfsr4 #(
   parameter int K     = 251,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_vld,
   input  logic             in_sop,
   input  logic [7:0]       in_data,
`ifdef RS_ENC_ERRINJ_EN
   input  logic [7:0]       err_inj,
`endif
   output logic             in_rdy,
   output logic             out_vld,
   output logic             out_sop,
   output logic             out_eop,
   output logic             out_par,
   output logic [7:0]       out_data
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_DATA   = 3'b010,
      ST_PARITY = 3'b100
   } state_t;

   localparam logic [CNT_W-1:0] c_k     = CNT_W'(K);
   localparam bit               c_k_one = (K == 1);

   state_t             r_state;
   logic [7:0]         r_p0, r_p1, r_p2, r_p3;
   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_pcnt;

   logic               w_xfer;
   logic [7:0]         w_mask;
   logic [7:0]         w_b0, w_b1, w_b2, w_b3;
   logic [7:0]         w_fb;
   logic [7:0]         w_n0, w_n1, w_n2, w_n3;
   logic [CNT_W-1:0]   w_cnt_nxt;

   // GF(2^8) multiply, reduction by x^8+x^4+x^3+x^2+1
   function automatic logic [7:0] gf2m8_multi(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return p;
   endfunction

`ifdef RS_ENC_ERRINJ_EN
   assign w_mask = err_inj;
`else
   assign w_mask = 8'h00;
`endif

   assign w_xfer    = in_vld & in_rdy;
   assign w_cnt_nxt = r_cnt + 1'b1;

   // LFSR next state; a new codeword starts from an all-zero register
   always_comb begin
      w_b0 = (r_state == ST_IDLE) ? 8'h00 : r_p0;
      w_b1 = (r_state == ST_IDLE) ? 8'h00 : r_p1;
      w_b2 = (r_state == ST_IDLE) ? 8'h00 : r_p2;
      w_b3 = (r_state == ST_IDLE) ? 8'h00 : r_p3;
      w_fb = in_data ^ w_b3;
      w_n3 = w_b2 ^ gf2m8_multi(w_fb, 8'h0F);
      w_n2 = w_b1 ^ gf2m8_multi(w_fb, 8'h36);
      w_n1 = w_b0 ^ gf2m8_multi(w_fb, 8'h78);
      w_n0 = gf2m8_multi(w_fb, 8'h40);
   end

   // Control FSM, LFSR and registered output stage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= `D ST_IDLE;
         r_p0     <= `D 8'h00;
         r_p1     <= `D 8'h00;
         r_p2     <= `D 8'h00;
         r_p3     <= `D 8'h00;
         r_cnt    <= `D '0;
         r_pcnt   <= `D 2'd0;
         in_rdy   <= `D 1'b1;
         out_vld  <= `D 1'b0;
         out_sop  <= `D 1'b0;
         out_eop  <= `D 1'b0;
         out_par  <= `D 1'b0;
         out_data <= `D 8'h00;
      end else begin
         out_vld <= `D 1'b0;
         out_sop <= `D 1'b0;
         out_eop <= `D 1'b0;
         out_par <= `D 1'b0;
         case (r_state)
            ST_IDLE: begin
               // without sop the symbol is silently discarded
               if (w_xfer && in_sop) begin
                  r_p3     <= `D w_n3;
                  r_p2     <= `D w_n2;
                  r_p1     <= `D w_n1;
                  r_p0     <= `D w_n0;
                  r_cnt    <= `D CNT_W'(1);
                  out_vld  <= `D 1'b1;
                  out_sop  <= `D 1'b1;
                  out_data <= `D in_data ^ w_mask;
                  if (c_k_one) begin
                     r_state <= `D ST_PARITY;
                     in_rdy  <= `D 1'b0;
                  end else begin
                     r_state <= `D ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               // in_sop is deliberately ignored here: every symbol is data
               if (w_xfer) begin
                  r_p3     <= `D w_n3;
                  r_p2     <= `D w_n2;
                  r_p1     <= `D w_n1;
                  r_p0     <= `D w_n0;
                  r_cnt    <= `D w_cnt_nxt;
                  out_vld  <= `D 1'b1;
                  out_data <= `D in_data ^ w_mask;
                  if (w_cnt_nxt == c_k) begin
                     r_state <= `D ST_PARITY;
                     in_rdy  <= `D 1'b0;
                  end
               end
            end
            ST_PARITY: begin
               // shift parity out highest degree first
               out_vld  <= `D 1'b1;
               out_par  <= `D 1'b1;
               out_data <= `D r_p3;
               r_p3     <= `D r_p2;
               r_p2     <= `D r_p1;
               r_p1     <= `D r_p0;
               r_p0     <= `D 8'h00;
               r_pcnt   <= `D r_pcnt + 2'd1;
               if (r_pcnt == 2'd3) begin
                  out_eop <= `D 1'b1;
                  r_state <= `D ST_IDLE;
                  in_rdy  <= `D 1'b1;
               end
            end
            default: begin
               r_state <= `D ST_IDLE;
               in_rdy  <= `D 1'b1;
               r_pcnt  <= `D 2'd0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_s0_rs_enc_lfsr4.sv
// ============================================================================
// Module   : tb_s0_rs_enc_lfsr4
// Brief    : Directed self-checking bench for s0_rs_enc_lfsr4 with K=4.
//            Define RS_ENC_ERRINJ_EN to include the error-injection scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_s0_rs_enc_lfsr4;

   localparam int K = 4;

   typedef struct {
      int         cyc;
      logic       sop;
      logic       eop;
      logic       par;
      logic [7:0] d;
   } ent_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       in_vld = 1'b0;
   logic       in_sop = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [7:0] err_inj = 8'h00;
   logic       in_rdy, out_vld, out_sop, out_eop, out_par;
   logic [7:0] out_data;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rdy_low = 0;
   logic stall_err = 1'b0;
   ent_t q[$];

   s0_rs_enc_lfsr4 #(.K(K), .CNT_W(8)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_vld   (in_vld),
      .in_sop   (in_sop),
      .in_data  (in_data),
`ifdef RS_ENC_ERRINJ_EN
      .err_inj  (err_inj),
`endif
      .in_rdy   (in_rdy),
      .out_vld  (out_vld),
      .out_sop  (out_sop),
      .out_eop  (out_eop),
      .out_par  (out_par),
      .out_data (out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // capture every output symbol and count stalled cycles
   always @(negedge clk) begin
      if (out_vld === 1'b1) q.push_back('{cyc, out_sop, out_eop, out_par, out_data});
      if (in_rdy !== 1'b1) rdy_low++;
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      while (y != 8'h00) begin
         if (y[0]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // evaluate the 8-symbol codeword starting at q[base] at the given root
   function automatic logic [7:0] synd(input int base, input logic [7:0] root);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 8; i++) s = gmul(s, root) ^ q[base+i].d;
      return s;
   endfunction

   task automatic idle(input int n);
      in_vld = 1'b0; in_sop = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic put(input logic s, input logic [7:0] d);
      logic r, ok;
      in_vld = 1'b1; in_sop = s; in_data = d; ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); r = in_rdy;
         @(posedge clk); #1; ok = r;
      end
      if (!ok) stall_err = 1'b1;
      in_vld = 1'b0; in_sop = 1'b0;
   endtask

   task automatic wait_q(input int n);
      for (int i = 0; i < 60 && q.size() < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      total++;
      if ({in_rdy, out_vld, out_sop, out_eop, out_par, out_data} !== 13'b1_0000_0000_0000) begin
         bad++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b sop=%b eop=%b par=%b data=%h, want 1 0 0 0 0 00",
                  in_rdy, out_vld, out_sop, out_eop, out_par, out_data);
      end
      @(posedge clk); #1; rstn = 1'b1;
      idle(2);
   endtask

   task automatic test_zero_word;
      q.delete(); rdy_low = 0;
      for (int i = 0; i < 4; i++) put(i == 0, 8'h00);
      wait_q(8); idle(3);
      total++;
      if (q.size() != 8) begin
         bad++; $display("FAIL zero_len: got %0d symbols, want 8", q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (q[i].d !== 8'h00 || q[i].sop !== (i == 0) || q[i].eop !== (i == 7) || q[i].par !== (i >= 4)) begin
               bad++;
               $display("FAIL zero_sym%0d: got d=%h sop=%b eop=%b par=%b, want d=00 sop=%b eop=%b par=%b",
                        i, q[i].d, q[i].sop, q[i].eop, q[i].par, i == 0, i == 7, i >= 4);
            end
         end
      end
      total++;
      if (rdy_low != 4) begin bad++; $display("FAIL zero_stall: got %0d low cycles, want 4", rdy_low); end
   endtask

   task automatic test_parity_table;
      logic [7:0] dl [3];
      logic [31:0] par [3];
      dl[0] = 8'h01; par[0] = 32'h0F367840;
      dl[1] = 8'h02; par[1] = 32'h1E6CF080;
      dl[2] = 8'h03; par[2] = 32'h115A88C0;
      for (int v = 0; v < 3; v++) begin
         logic [31:0] pv;
         pv = par[v];
         q.delete();
         put(1'b1, 8'h00); put(1'b0, 8'h00); put(1'b0, 8'h00); put(1'b0, dl[v]);
         wait_q(8); idle(2);
         total++;
         if (q.size() != 8) begin
            bad++; $display("FAIL table%0d_len: got %0d symbols, want 8", v, q.size());
         end else begin
            total++;
            if ({q[4].d, q[5].d, q[6].d, q[7].d} !== pv || q[3].d !== dl[v] || q[7].eop !== 1'b1) begin
               bad++;
               $display("FAIL table%0d_parity: got d3=%h par=%h%h%h%h eop=%b, want d3=%h par=%h eop=1",
                        v, q[3].d, q[4].d, q[5].d, q[6].d, q[7].d, q[7].eop, dl[v], pv);
            end
            total++;
            if ({synd(0, 8'h01), synd(0, 8'h02), synd(0, 8'h04), synd(0, 8'h08)} !== 32'h0) begin
               bad++; $display("FAIL table%0d_synd: got nonzero syndrome, want 0", v);
            end
         end
      end
   endtask

   task automatic test_syndrome_gaps;
      for (int w = 0; w < 3; w++) begin
         logic [7:0] d [4];
         q.delete(); rdy_low = 0;
         for (int i = 0; i < 4; i++) begin
            d[i] = 8'($urandom_range(0, 255));
            put(i == 0, d[i]);
            idle($urandom_range(0, 2));
         end
         wait_q(8); idle(3);
         total++;
         if (q.size() != 8) begin
            bad++; $display("FAIL gaps%0d_len: got %0d symbols, want 8", w, q.size());
         end else begin
            total++;
            if ({q[0].d, q[1].d, q[2].d, q[3].d} !== {d[0], d[1], d[2], d[3]}) begin
               bad++; $display("FAIL gaps%0d_data: got %h%h%h%h, want %h%h%h%h", w,
                               q[0].d, q[1].d, q[2].d, q[3].d, d[0], d[1], d[2], d[3]);
            end
            total++;
            if ({synd(0, 8'h01), synd(0, 8'h02), synd(0, 8'h04), synd(0, 8'h08)} !== 32'h0) begin
               bad++; $display("FAIL gaps%0d_synd: got S=%h %h %h %h, want 0", w,
                               synd(0, 8'h01), synd(0, 8'h02), synd(0, 8'h04), synd(0, 8'h08));
            end
         end
         total++;
         if (rdy_low != 4) begin bad++; $display("FAIL gaps%0d_stall: got %0d, want 4", w, rdy_low); end
      end
   endtask

   task automatic test_back_to_back;
      q.delete(); rdy_low = 0;
      put(1'b1, 8'h11); put(1'b0, 8'h22); put(1'b0, 8'h33); put(1'b0, 8'h44);
      put(1'b1, 8'h00); put(1'b0, 8'h00); put(1'b0, 8'h00); put(1'b0, 8'h01);
      wait_q(16); idle(3);
      total++;
      if (q.size() != 16) begin
         bad++; $display("FAIL b2b_len: got %0d symbols, want 16", q.size());
      end else begin
         total++;
         if (q[7].eop !== 1'b1 || q[8].sop !== 1'b1 || q[8].cyc != q[7].cyc + 1) begin
            bad++; $display("FAIL b2b_turnaround: got eop=%b sop=%b gap=%0d, want 1 1 1",
                            q[7].eop, q[8].sop, q[8].cyc - q[7].cyc);
         end
         total++;
         if ({synd(0, 8'h01), synd(0, 8'h02), synd(0, 8'h04), synd(0, 8'h08)} !== 32'h0) begin
            bad++; $display("FAIL b2b_word1_synd: got nonzero syndrome, want 0");
         end
         total++;
         if ({q[12].d, q[13].d, q[14].d, q[15].d} !== 32'h0F367840 || q[15].eop !== 1'b1) begin
            bad++; $display("FAIL b2b_word2_parity: got %h%h%h%h eop=%b, want 0F367840 eop=1",
                            q[12].d, q[13].d, q[14].d, q[15].d, q[15].eop);
         end
      end
      total++;
      if (rdy_low != 8) begin bad++; $display("FAIL b2b_stall: got %0d, want 8", rdy_low); end
   endtask

   task automatic test_drop_and_mid_sop;
      logic [63:0] exp;
      exp = 64'h00000001_0F367840;
      q.delete();
      put(1'b0, 8'hAA); put(1'b0, 8'hBB); idle(3);
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL drop_nosop: got %0d symbols, want 0", q.size()); end
      q.delete();
      put(1'b1, 8'h00); put(1'b0, 8'h00); put(1'b1, 8'h00); put(1'b0, 8'h01);
      wait_q(8); idle(6);
      total++;
      if (q.size() != 8) begin
         bad++; $display("FAIL midsop_len: got %0d symbols, want 8", q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            logic [63:0] e;
            e = exp >> (8 * (7 - i));
            total++;
            if (q[i].d !== e[7:0] || q[i].sop !== (i == 0) || q[i].par !== (i >= 4)) begin
               bad++; $display("FAIL midsop_sym%0d: got d=%h sop=%b par=%b, want d=%h sop=%b par=%b",
                               i, q[i].d, q[i].sop, q[i].par, e[7:0], i == 0, i >= 4);
            end
         end
      end
   endtask

   task automatic test_mid_reset;
      logic [63:0] exp;
      exp = 64'h00000001_0F367840;
      put(1'b1, 8'h5A); put(1'b0, 8'hC3);
      #2 rstn = 1'b0;
      #1;
      total++;
      if ({in_rdy, out_vld, out_sop, out_eop, out_par, out_data} !== 13'b1_0000_0000_0000) begin
         bad++; $display("FAIL midrst_async: got rdy=%b vld=%b data=%h, want 1 0 00", in_rdy, out_vld, out_data);
      end
      @(posedge clk); #1; rstn = 1'b1;
      idle(1);
      q.delete();
      put(1'b1, 8'h00); put(1'b0, 8'h00); put(1'b0, 8'h00); put(1'b0, 8'h01);
      wait_q(8); idle(8);
      total++;
      if (q.size() != 8) begin
         bad++; $display("FAIL midrst_len: got %0d symbols, want 8", q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            logic [63:0] e;
            e = exp >> (8 * (7 - i));
            total++;
            if (q[i].d !== e[7:0] || q[i].sop !== (i == 0) || q[i].eop !== (i == 7)) begin
               bad++; $display("FAIL midrst_sym%0d: got d=%h sop=%b eop=%b, want d=%h sop=%b eop=%b",
                               i, q[i].d, q[i].sop, q[i].eop, e[7:0], i == 0, i == 7);
            end
         end
      end
   endtask

`ifdef RS_ENC_ERRINJ_EN
   task automatic test_err_inj;
      logic [63:0] exp;
      exp = 64'h00000101_0F367840;
      q.delete();
      put(1'b1, 8'h00); put(1'b0, 8'h00);
      err_inj = 8'h01; put(1'b0, 8'h00); err_inj = 8'h00;
      put(1'b0, 8'h01);
      wait_q(8); idle(3);
      total++;
      if (q.size() != 8) begin
         bad++; $display("FAIL errinj_len: got %0d symbols, want 8", q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            logic [63:0] e;
            e = exp >> (8 * (7 - i));
            total++;
            if (q[i].d !== e[7:0]) begin
               bad++; $display("FAIL errinj_sym%0d: got %h, want %h", i, q[i].d, e[7:0]);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_zero_word();
      test_parity_table();
      test_syndrome_gaps();
      test_back_to_back();
      test_drop_and_mid_sop();
      test_mid_reset();
`ifdef RS_ENC_ERRINJ_EN
      test_err_inj();
`endif
      total++;
      if (stall_err !== 1'b0) begin bad++; $display("FAIL handshake: got stall timeout=1, want 0"); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
